// File: rtl/x86_prefix_parser.sv
// Byte-serial x86 prefix/opcode parser: strips legacy and REX prefixes and
// assembles the 1-3 byte opcode, holding the record until downstream takes it.
module x86_prefix_parser (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  lock_repeat_prefix,
    output logic [7:0]  segment_branch_prefix,
    output logic [7:0]  operand_size_prefix,
    output logic [7:0]  address_size_prefix,
    output logic [7:0]  rex_prefix,
    output logic [23:0] opcode,
    output logic [1:0]  opcode_len,
    output logic [3:0]  byte_count,
    output logic        out_error
);

    // state  | meaning
    // PREFIX | expecting a prefix or the first opcode byte
    // OP2    | first opcode byte was 0F
    // OP3    | saw 0F 38 or 0F 3A
    // HOLD   | record valid, waiting for out_ready
    typedef enum logic [1:0] {
        ST_PREFIX = 2'd0,
        ST_OP2    = 2'd1,
        ST_OP3    = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [3:0] MAX_LEN = 4'd15;

    state_t      state, state_nxt;
    logic [7:0]  lr_nxt, sg_nxt, os_nxt, as_nxt, rex_nxt;
    logic [23:0] op_nxt;
    logic [1:0]  len_nxt;
    logic [3:0]  cnt_nxt;
    logic        err_nxt;
    logic        accept;
    logic        last_byte;

    assign in_ready  = (state != ST_HOLD);
    assign out_valid = (state == ST_HOLD);
    assign accept    = in_valid && in_ready;
    // This accepted byte is the 15th; if it does not finish the opcode the record is an error.
    assign last_byte = (byte_count == MAX_LEN - 4'd1);

    always_comb begin
        state_nxt = state;
        lr_nxt    = lock_repeat_prefix;
        sg_nxt    = segment_branch_prefix;
        os_nxt    = operand_size_prefix;
        as_nxt    = address_size_prefix;
        rex_nxt   = rex_prefix;
        op_nxt    = opcode;
        len_nxt   = opcode_len;
        cnt_nxt   = byte_count;
        err_nxt   = out_error;

        if (flush) begin
            state_nxt = ST_PREFIX;
            lr_nxt    = 8'h00;
            sg_nxt    = 8'h00;
            os_nxt    = 8'h00;
            as_nxt    = 8'h00;
            rex_nxt   = 8'h00;
            op_nxt    = 24'h0;
            len_nxt   = 2'd0;
            cnt_nxt   = 4'd0;
            err_nxt   = 1'b0;
        end else begin
            if (accept && byte_count != MAX_LEN)
                cnt_nxt = byte_count + 4'd1;

            case (state)
                ST_PREFIX: begin
                    if (accept) begin
                        unique case (in_byte) inside
                            8'hF0, 8'hF2, 8'hF3: begin
                                lr_nxt  = in_byte;
                                rex_nxt = 8'h00;
                            end
                            8'h2E, 8'h36, 8'h3E, 8'h26, 8'h64, 8'h65: begin
                                sg_nxt  = in_byte;
                                rex_nxt = 8'h00;
                            end
                            8'h66: begin
                                os_nxt  = in_byte;
                                rex_nxt = 8'h00;
                            end
                            8'h67: begin
                                as_nxt  = in_byte;
                                rex_nxt = 8'h00;
                            end
                            [8'h40:8'h4F]: rex_nxt = in_byte;
                            default: begin
                                op_nxt[23:16] = in_byte;
                                if (in_byte == 8'h0F) begin
                                    state_nxt = ST_OP2;
                                end else begin
                                    state_nxt = ST_HOLD;
                                    len_nxt   = 2'd1;
                                end
                            end
                        endcase
                        if (last_byte && state_nxt != ST_HOLD) begin
                            state_nxt = ST_HOLD;
                            len_nxt   = 2'd0;
                            err_nxt   = 1'b1;
                        end
                    end
                end
                ST_OP2: begin
                    if (accept) begin
                        op_nxt[15:8] = in_byte;
                        if (in_byte == 8'h38 || in_byte == 8'h3A) begin
                            if (last_byte) begin
                                state_nxt = ST_HOLD;
                                len_nxt   = 2'd0;
                                err_nxt   = 1'b1;
                            end else begin
                                state_nxt = ST_OP3;
                            end
                        end else begin
                            state_nxt = ST_HOLD;
                            len_nxt   = 2'd2;
                        end
                    end
                end
                ST_OP3: begin
                    if (accept) begin
                        op_nxt[7:0] = in_byte;
                        state_nxt   = ST_HOLD;
                        len_nxt     = 2'd3;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_nxt = ST_PREFIX;
                        lr_nxt    = 8'h00;
                        sg_nxt    = 8'h00;
                        os_nxt    = 8'h00;
                        as_nxt    = 8'h00;
                        rex_nxt   = 8'h00;
                        op_nxt    = 24'h0;
                        len_nxt   = 2'd0;
                        cnt_nxt   = 4'd0;
                        err_nxt   = 1'b0;
                    end
                end
                default: state_nxt = ST_PREFIX;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state                 <= ST_PREFIX;
            lock_repeat_prefix    <= 8'h00;
            segment_branch_prefix <= 8'h00;
            operand_size_prefix   <= 8'h00;
            address_size_prefix   <= 8'h00;
            rex_prefix            <= 8'h00;
            opcode                <= 24'h0;
            opcode_len            <= 2'd0;
            byte_count            <= 4'd0;
            out_error             <= 1'b0;
        end else begin
            state                 <= state_nxt;
            lock_repeat_prefix    <= lr_nxt;
            segment_branch_prefix <= sg_nxt;
            operand_size_prefix   <= os_nxt;
            address_size_prefix   <= as_nxt;
            rex_prefix            <= rex_nxt;
            opcode                <= op_nxt;
            opcode_len            <= len_nxt;
            byte_count            <= cnt_nxt;
            out_error             <= err_nxt;
        end
    end

endmodule

// File: tb/tb_x86_prefix_parser.sv
// Directed bench for x86_prefix_parser: expected records are queued when an
// instruction is driven and compared when the DUT presents out_valid.
module tb_x86_prefix_parser;

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_byte;
    logic [7:0]  lock_repeat_prefix, segment_branch_prefix, operand_size_prefix;
    logic [7:0]  address_size_prefix, rex_prefix;
    logic [23:0] opcode;
    logic [1:0]  opcode_len;
    logic [3:0]  byte_count;
    logic        out_error;

    typedef struct packed {
        logic [7:0]  lr, sg, os, as, rex;
        logic [23:0] op;
        logic [1:0]  len;
        logic [3:0]  cnt;
        logic        err;
    } rec_t;

    rec_t       exp_q[$];
    logic [7:0] stim[$];
    int         n_cmp  = 0;
    int         n_fail = 0;

    x86_prefix_parser dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .lock_repeat_prefix(lock_repeat_prefix),
        .segment_branch_prefix(segment_branch_prefix),
        .operand_size_prefix(operand_size_prefix),
        .address_size_prefix(address_size_prefix),
        .rex_prefix(rex_prefix), .opcode(opcode), .opcode_len(opcode_len),
        .byte_count(byte_count), .out_error(out_error)
    );

    always #5 clk = ~clk;

    function automatic rec_t mk(input logic [7:0] lr, sg, os, as, rex,
                                input logic [23:0] op, input logic [1:0] len,
                                input logic [3:0] cnt, input logic err);
        mk = '{lr: lr, sg: sg, os: os, as: as, rex: rex, op: op, len: len, cnt: cnt, err: err};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_fields(input string tag, input rec_t e);
        check({tag, ".lr"},  32'(lock_repeat_prefix),    32'(e.lr));
        check({tag, ".sg"},  32'(segment_branch_prefix), 32'(e.sg));
        check({tag, ".os"},  32'(operand_size_prefix),   32'(e.os));
        check({tag, ".as"},  32'(address_size_prefix),   32'(e.as));
        check({tag, ".rex"}, 32'(rex_prefix),            32'(e.rex));
        check({tag, ".op"},  32'(opcode),                32'(e.op));
        check({tag, ".len"}, 32'(opcode_len),            32'(e.len));
        check({tag, ".cnt"}, 32'(byte_count),            32'(e.cnt));
        check({tag, ".err"}, 32'(out_error),             32'(e.err));
    endtask

    // Drive stim[] one byte per cycle (DUT is never in HOLD mid-instruction).
    task automatic drive();
        foreach (stim[i]) begin
            in_valid = 1'b1;
            in_byte  = stim[i];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_byte  = 8'h00;
    endtask

    // Wait for a record right after drive(), check latency and fields against the queue head.
    task automatic expect_rec(input string tag);
        rec_t e;
        int   waited = 0;
        @(negedge clk);
        while (!out_valid && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!out_valid) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s.timeout: observed out_valid 0 expected 1", tag);
            return;
        end
        check({tag, ".latency"}, 32'(waited), 32'd0);
        check({tag, ".in_ready"}, 32'(in_ready), 32'd0);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s.queue: observed empty expected entry", tag);
            return;
        end
        e = exp_q.pop_front();
        check_fields(tag, e);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".in_ready"},  32'(in_ready),  32'd1);
        check_fields(tag, mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 24'h0, 2'd0, 4'd0, 1'b0));
    endtask

    initial begin
        rec_t hold_rec;
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_byte = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        check_idle("reset");

        // single-byte opcode
        stim = '{8'h90};
        exp_q.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 24'h900000, 2'd1, 4'd1, 1'b0));
        drive(); expect_rec("nop"); take();
        check_idle("after_take");

        stim = '{8'h66, 8'h48, 8'h0F, 8'hAF};
        exp_q.push_back(mk(8'h00, 8'h00, 8'h66, 8'h00, 8'h48, 24'h0FAF00, 2'd2, 4'd4, 1'b0));
        drive(); expect_rec("imul"); take();

        stim = '{8'h48, 8'h66, 8'h89};
        exp_q.push_back(mk(8'h00, 8'h00, 8'h66, 8'h00, 8'h00, 24'h890000, 2'd1, 4'd3, 1'b0));
        drive(); expect_rec("rex_drop"); take();

        stim = '{8'hF2, 8'hF3, 8'h2E, 8'h3E, 8'h8B};
        exp_q.push_back(mk(8'hF3, 8'h3E, 8'h00, 8'h00, 8'h00, 24'h8B0000, 2'd1, 4'd5, 1'b0));
        drive(); expect_rec("last_wins"); take();

        stim = '{8'h67, 8'h41, 8'h4C, 8'h01};
        exp_q.push_back(mk(8'h00, 8'h00, 8'h00, 8'h67, 8'h4C, 24'h010000, 2'd1, 4'd4, 1'b0));
        drive(); expect_rec("rex_rex"); take();

        stim = '{8'h66, 8'h0F, 8'h3A, 8'h0F};
        exp_q.push_back(mk(8'h00, 8'h00, 8'h66, 8'h00, 8'h00, 24'h0F3A0F, 2'd3, 4'd4, 1'b0));
        drive(); expect_rec("op3"); take();

        stim = '{8'h0F, 8'h66};
        exp_q.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 24'h0F6600, 2'd2, 4'd2, 1'b0));
        drive(); expect_rec("op2_66"); take();

        // fourteen prefixes plus a one-byte opcode is exactly legal
        stim.delete();
        repeat (14) stim.push_back(8'h26);
        stim.push_back(8'hC3);
        exp_q.push_back(mk(8'h00, 8'h26, 8'h00, 8'h00, 8'h00, 24'hC30000, 2'd1, 4'd15, 1'b0));
        drive(); expect_rec("len15_ok"); take();

        stim.delete();
        repeat (15) stim.push_back(8'h66);
        exp_q.push_back(mk(8'h00, 8'h00, 8'h66, 8'h00, 8'h00, 24'h0, 2'd0, 4'd15, 1'b1));
        drive(); expect_rec("len_err");
        in_valid = 1'b1; in_byte = 8'h90;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("len_err.blocked_ready", 32'(in_ready), 32'd0);
        check("len_err.blocked_cnt",   32'(byte_count), 32'd15);
        in_valid = 1'b0;
        take();

        // thirteen prefixes then 0F 38: the 15th byte leaves the opcode open
        stim.delete();
        repeat (13) stim.push_back(8'h64);
        stim.push_back(8'h0F);
        stim.push_back(8'h38);
        exp_q.push_back(mk(8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 24'h0F3800, 2'd0, 4'd15, 1'b1));
        drive(); expect_rec("len_err_op3"); take();

        // backpressure: record stable with out_ready low
        stim = '{8'hF0, 8'h0F, 8'hB1};
        hold_rec = mk(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 24'h0FB100, 2'd2, 4'd3, 1'b0);
        exp_q.push_back(hold_rec);
        drive(); expect_rec("bp");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp.out_valid", 32'(out_valid), 32'd1);
            check("bp.in_ready",  32'(in_ready),  32'd0);
            check("bp.op",        32'(opcode),    32'(hold_rec.op));
            check("bp.cnt",       32'(byte_count), 32'(hold_rec.cnt));
        end
        take();

        // flush in HOLD discards the record
        stim = '{8'h0F, 8'h05};
        exp_q.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 24'h0F0500, 2'd2, 4'd2, 1'b0));
        drive(); expect_rec("pre_flush");
        flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
        check_idle("flush_hold");

        // flush mid-prefix drops the byte presented alongside it
        stim = '{8'hF3};
        drive();
        flush = 1'b1; in_valid = 1'b1; in_byte = 8'h66;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check_idle("flush_mid");
        stim = '{8'h90};
        exp_q.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 24'h900000, 2'd1, 4'd1, 1'b0));
        drive(); expect_rec("post_flush"); take();

        // reset mid-prefix
        stim = '{8'hF0, 8'h2E};
        drive();
        reset_n = 1'b0; @(posedge clk); #1; reset_n = 1'b1;
        check_idle("reset_mid");
        stim = '{8'h90};
        exp_q.push_back(mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 24'h900000, 2'd1, 4'd1, 1'b0));
        drive(); expect_rec("post_reset"); take();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
